// File: rtl/stopwatch_ctrl.sv
// Stopwatch control block: input synchronisers, press-edge detection and the
// mode FSM that issues increment and clear strobes to the time counters.
// Optional feature macro: LAP_SPLIT_EN adds btn_lap and a lap_hold output.
module stopwatch_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_pause,
    input  logic       btn_reset,
`ifdef LAP_SPLIT_EN
    input  logic       btn_lap,
    output logic       lap_hold,
`endif
    input  logic       sw_adj,
    input  logic       sw_sel,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       sec_at_59,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       clear,
    output logic       blink_min,
    output logic       blink_sec,
    output logic       running,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSED  = 3'd2,
        ADJ_MIN = 3'd3,
        ADJ_SEC = 3'd4
    } state_e;

    localparam int BTN_PAUSE = 0;
    localparam int BTN_CLEAR = 1;
`ifdef LAP_SPLIT_EN
    localparam int BTN_LAP   = 2;
    localparam int NBTN      = 3;
`else
    localparam int NBTN      = 2;
`endif

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_lvl;
    logic [NBTN-1:0] btn_hist_q;
    logic [NBTN-1:0] btn_armed_q;
    logic [NBTN-1:0] btn_press_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [SYNC_STAGES-1:0] adj_sync_q;
    logic [SYNC_STAGES-1:0] sel_sync_q;

`ifdef LAP_SPLIT_EN
    assign btn_raw = {btn_lap, btn_reset, btn_pause};
`else
    assign btn_raw = {btn_reset, btn_pause};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_q;
            // Metastability chain for one button level.
            always_ff @(posedge clk_100MHz or posedge reset) begin
                if (reset) sync_q <= '0;
                else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
            end
            assign btn_lvl[gi] = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Switch synchronisers plus a fill marker that shows when the chains hold
    // genuine post-reset samples rather than reset zeros.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            adj_sync_q <= '0;
            sel_sync_q <= '0;
            fill_q     <= '0;
        end else begin
            adj_sync_q <= {adj_sync_q[SYNC_STAGES-2:0], sw_adj};
            sel_sync_q <= {sel_sync_q[SYNC_STAGES-2:0], sw_sel};
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Registered press pulses; a button only arms once it has been seen low
    // after reset, so a button held through reset release never fires.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            btn_hist_q  <= '0;
            btn_armed_q <= '0;
            btn_press_q <= '0;
        end else begin
            btn_hist_q  <= btn_lvl;
            btn_armed_q <= btn_armed_q | ({NBTN{fill_q[SYNC_STAGES-1]}} & ~btn_lvl);
            btn_press_q <= btn_armed_q & btn_lvl & ~btn_hist_q;
        end
    end

    logic pause_p, clear_p, adj_s, sel_s;
    assign pause_p = btn_press_q[BTN_PAUSE];
    assign clear_p = btn_press_q[BTN_CLEAR];
    assign adj_s   = adj_sync_q[SYNC_STAGES-1];
    assign sel_s   = sel_sync_q[SYNC_STAGES-1];

    state_e state_q, state_d;
    logic   sec_inc_q, sec_inc_d;
    logic   min_inc_q, min_inc_d;
    logic   clear_q, clear_d;
    logic   running_q, blink_min_q, blink_sec_q;

    // Next-state and strobe decode; clear wins over everything else.
    always_comb begin
        state_d   = state_q;
        sec_inc_d = 1'b0;
        min_inc_d = 1'b0;
        clear_d   = 1'b0;
        if (clear_p) begin
            state_d = IDLE;
            clear_d = 1'b1;
        end else begin
            case (state_q)
                IDLE, PAUSED: begin
                    if (adj_s)        state_d = sel_s ? ADJ_SEC : ADJ_MIN;
                    else if (pause_p) state_d = RUN;
                end
                RUN: begin
                    if (tick_1hz) begin
                        sec_inc_d = 1'b1;
                        min_inc_d = sec_at_59;
                    end
                    if (adj_s)        state_d = sel_s ? ADJ_SEC : ADJ_MIN;
                    else if (pause_p) state_d = PAUSED;
                end
                ADJ_MIN: begin
                    min_inc_d = tick_2hz;
                    if (!adj_s)     state_d = PAUSED;
                    else if (sel_s) state_d = ADJ_SEC;
                end
                ADJ_SEC: begin
                    sec_inc_d = tick_2hz;
                    if (!adj_s)      state_d = PAUSED;
                    else if (!sel_s) state_d = ADJ_MIN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sec_inc_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            clear_q     <= 1'b0;
            running_q   <= 1'b0;
            blink_min_q <= 1'b0;
            blink_sec_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_inc_q   <= sec_inc_d;
            min_inc_q   <= min_inc_d;
            clear_q     <= clear_d;
            running_q   <= (state_d == RUN);
            blink_min_q <= (state_d == ADJ_MIN);
            blink_sec_q <= (state_d == ADJ_SEC);
        end
    end

`ifdef LAP_SPLIT_EN
    logic lap_hold_q, lap_hold_d;

    // Lap toggles only while running, survives pause, drops on idle/adjust.
    always_comb begin
        lap_hold_d = lap_hold_q;
        if (state_d == IDLE || state_d == ADJ_MIN || state_d == ADJ_SEC)
            lap_hold_d = 1'b0;
        else if (state_q == RUN && btn_press_q[BTN_LAP])
            lap_hold_d = ~lap_hold_q;
    end

    // Lap hold register.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) lap_hold_q <= 1'b0;
        else       lap_hold_q <= lap_hold_d;
    end

    assign lap_hold = lap_hold_q;
`endif

    assign state     = state_q;
    assign sec_inc   = sec_inc_q;
    assign min_inc   = min_inc_q;
    assign clear     = clear_q;
    assign running   = running_q;
    assign blink_min = blink_min_q;
    assign blink_sec = blink_sec_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: table of mode/tick vectors with a
// scoreboard queue, plus hand sequences for latency, clear priority and reset.
module tb_stopwatch_ctrl;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_pause = 1'b0, btn_reset = 1'b0;
    logic       sw_adj = 1'b0, sw_sel = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, sec_at_59 = 1'b0;
    logic       sec_inc, min_inc, clear, blink_min, blink_sec, running;
    logic [2:0] state;
`ifdef LAP_SPLIT_EN
    logic       btn_lap = 1'b0;
    logic       lap_hold;
`endif

    always #5 clk = ~clk;

    stopwatch_ctrl #(.SYNC_STAGES(N)) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .btn_pause  (btn_pause),
        .btn_reset  (btn_reset),
`ifdef LAP_SPLIT_EN
        .btn_lap    (btn_lap),
        .lap_hold   (lap_hold),
`endif
        .sw_adj     (sw_adj),
        .sw_sel     (sw_sel),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .sec_at_59  (sec_at_59),
        .sec_inc    (sec_inc),
        .min_inc    (min_inc),
        .clear      (clear),
        .blink_min  (blink_min),
        .blink_sec  (blink_sec),
        .running    (running),
        .state      (state)
    );

    typedef struct {
        logic [2:0] st;
        logic       sec;
        logic       mn;
    } exp_t;

    typedef struct {
        logic adj, sel, press, t1, t2, s59;
        exp_t e;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t tbl[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit past the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n, inout int strobes);
        for (int k = 0; k < n; k++) begin
            cycle();
            strobes += int'(sec_inc) + int'(min_inc) + int'(clear);
        end
    endtask

    task automatic check_state(input string nm, input logic [2:0] st);
        chk({nm, " state"}, 8'(state), 8'(st));
        chk({nm, " running"}, 8'(running), 8'(st == 3'd1));
        chk({nm, " blink_min"}, 8'(blink_min), 8'(st == 3'd3));
        chk({nm, " blink_sec"}, 8'(blink_sec), 8'(st == 3'd4));
    endtask

    task automatic apply(input int idx, input vec_t v);
        int   q = 0;
        exp_t e;
        string nm;
        nm = $sformatf("vec%0d", idx);
        sw_adj = v.adj;
        sw_sel = v.sel;
        btn_pause = v.press;
        settle(N + 4, q);
        btn_pause = 1'b0;
        settle(N + 4, q);
        chk({nm, " quiet"}, 8'(q), 8'd0);
        tick_1hz = v.t1;
        tick_2hz = v.t2;
        sec_at_59 = v.s59;
        sb_q.push_back(v.e);
        cycle();
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        sec_at_59 = 1'b0;
        e = sb_q.pop_front();
        check_state(nm, e.st);
        chk({nm, " sec_inc"}, 8'(sec_inc), 8'(e.sec));
        chk({nm, " min_inc"}, 8'(min_inc), 8'(e.mn));
        chk({nm, " clear"}, 8'(clear), 8'd0);
        $display("vec%0d adj=%0d sel=%0d press=%0d t1=%0d t2=%0d s59=%0d -> state=%0d sec_inc=%0d min_inc=%0d",
                 idx, v.adj, v.sel, v.press, v.t1, v.t2, v.s59, state, sec_inc, min_inc);
    endtask

    initial begin
        int q;
        //          adj  sel  prs  t1   t2   s59   state sec  min
        tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,'{3'd1,1'b1,1'b0}};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,'{3'd1,1'b1,1'b0}};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,'{3'd1,1'b1,1'b0}};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,'{3'd1,1'b1,1'b1}};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,'{3'd1,1'b0,1'b0}};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,'{3'd3,1'b0,1'b1}};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,'{3'd3,1'b0,1'b1}};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,'{3'd3,1'b0,1'b0}};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,'{3'd4,1'b1,1'b0}};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,'{3'd4,1'b1,1'b0}};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,'{3'd2,1'b0,1'b0}};
        tbl[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,'{3'd1,1'b1,1'b0}};
        tbl[12] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,'{3'd2,1'b0,1'b0}};

        // Reset state
        repeat (3) cycle();
        check_state("reset", 3'd0);
        chk("reset sec_inc", 8'(sec_inc), 8'd0);
        chk("reset min_inc", 8'(min_inc), 8'd0);
        chk("reset clear", 8'(clear), 8'd0);
        $display("reset: state=%0d running=%0d", state, running);
        reset = 1'b0;
        q = 0;
        settle(N + 4, q);
        chk("post-reset quiet", 8'(q), 8'd0);

        for (int i = 0; i < 13; i++) apply(i, tbl[i]);

        // Button latency: state changes exactly SYNC_STAGES+2 edges after toggle
        btn_pause = 1'b1;
        repeat (N + 1) cycle();
        chk("latency early", 8'(state), 8'd2);
        cycle();
        chk("latency edge", 8'(state), 8'd1);
        $display("latency: state=%0d after %0d cycles", state, N + 2);
        btn_pause = 1'b0;
        q = 0;
        settle(N + 4, q);

        // Clear and pause press together, coincident with a 1 Hz tick in RUN
        btn_pause = 1'b1;
        btn_reset = 1'b1;
        repeat (N + 1) cycle();
        tick_1hz = 1'b1;
        sec_at_59 = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        sec_at_59 = 1'b0;
        chk("clrprio state", 8'(state), 8'd0);
        chk("clrprio clear", 8'(clear), 8'd1);
        chk("clrprio sec_inc", 8'(sec_inc), 8'd0);
        chk("clrprio min_inc", 8'(min_inc), 8'd0);
        cycle();
        chk("clrprio clear 1cyc", 8'(clear), 8'd0);
        chk("clrprio stay idle", 8'(state), 8'd0);
        $display("clear priority: state=%0d clear=%0d", state, clear);
        btn_pause = 1'b0;
        btn_reset = 1'b0;
        q = 0;
        settle(N + 4, q);

        // Reset mid-RUN with btn_pause held and a tick in flight
        btn_pause = 1'b1;
        q = 0;
        settle(N + 4, q);
        chk("midrst run", 8'(state), 8'd1);
        tick_1hz = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst async running", 8'(running), 8'd0);
        chk("midrst async state", 8'(state), 8'd0);
        tick_1hz = 1'b0;
        cycle();
        chk("midrst dropped sec_inc", 8'(sec_inc), 8'd0);
        cycle();
        reset = 1'b0;
        q = 0;
        settle(N + 6, q);
        chk("midrst held no press", 8'(state), 8'd0);
        btn_pause = 1'b0;
        settle(N + 4, q);
        chk("midrst low stays idle", 8'(state), 8'd0);
        btn_pause = 1'b1;
        settle(N + 4, q);
        chk("midrst repress run", 8'(state), 8'd1);
        chk("midrst quiet", 8'(q), 8'd0);
        $display("mid-run reset: final state=%0d", state);
        btn_pause = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on each button and switch input; legal range 2..4.
REQ-002 clk_100MHz  input  1  single system clock; every flop in the block is clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 btn_pause  input  1  debounced pause button level; asynchronous to clk_100MHz.
REQ-005 btn_reset  input  1  debounced clear button level; asynchronous to clk_100MHz.
REQ-006 sw_adj  input  1  ADJ slider switch: 1 = adjust mode.
REQ-007 sw_sel  input  1  SEL slider switch: 0 = minutes, 1 = seconds.
REQ-008 tick_1hz  input  1  one-cycle strobe at 1 Hz; synchronous to clk_100MHz.
REQ-009 tick_2hz  input  1  one-cycle strobe at 2 Hz; synchronous to clk_100MHz.
REQ-010 sec_at_59  input  1  high when the seconds counter reads 59.
REQ-011 sec_inc  output  1  one-cycle seconds-increment strobe.
REQ-012 min_inc  output  1  one-cycle minutes-increment strobe.
REQ-013 clear  output  1  one-cycle strobe that zeroes both counters.
REQ-014 blink_min, blink_sec  output  1 each  select which display field blinks.
REQ-015 running  output  1  high only in state RUN.
REQ-016 state  output  3  current state code.

Function
REQ-017 Button and switch inputs SHALL pass through SYNC_STAGES flops; after that, button rising edges SHALL be detected with one further flop, giving press pulses pause_p and clear_p.
REQ-018 State codes SHALL be IDLE=0, RUN=1, PAUSED=2, ADJ_MIN=3, ADJ_SEC=4; codes 5-7 SHALL return to IDLE on the next clock.
REQ-019 clear_p in any state SHALL move the FSM to IDLE and assert clear for exactly one cycle.
REQ-020 clear_p SHALL take priority over every other event in the same cycle, and no inc strobe SHALL be issued in that cycle.
REQ-021 In IDLE or PAUSED:
- synced sw_adj=1 SHALL move the FSM to ADJ_SEC if synced sw_sel=1, else to ADJ_MIN;
- otherwise pause_p SHALL move the FSM to RUN.
REQ-022 In RUN, tick_1hz SHALL assert sec_inc in the next cycle.
REQ-023 In RUN, min_inc SHALL be asserted in that same cycle if sec_at_59=1 at the tick.
REQ-024 In RUN, pause_p SHALL move the FSM to PAUSED.
REQ-025 In RUN, sw_adj=1 SHALL move the FSM to ADJ_SEC or ADJ_MIN per sw_sel; adj takes precedence over pause_p.
REQ-026 If a tick and a transition out of RUN occur in the same cycle, the tick's increment SHALL still be issued.
REQ-027 In ADJ_MIN, tick_2hz SHALL assert min_inc only; in ADJ_SEC, tick_2hz SHALL assert sec_inc only, with no carry to min_inc.
REQ-028 In ADJ_MIN or ADJ_SEC, a change of sw_sel SHALL switch between the two ADJ states on the next clock.
REQ-029 In ADJ_MIN or ADJ_SEC, sw_adj=0 SHALL move the FSM to PAUSED; leaving adjust never resumes counting.
REQ-030 pause_p SHALL be ignored in ADJ_MIN and ADJ_SEC.
REQ-031 tick_1hz SHALL be ignored outside RUN; tick_2hz SHALL be ignored outside the ADJ states.
REQ-032 All outputs SHALL be registered.
REQ-033 Latency: a button edge SHALL change state SYNC_STAGES+2 cycles after the input toggles; a tick SHALL produce an inc strobe 1 cycle after the tick.
REQ-034 blink_min SHALL be high only in ADJ_MIN, and blink_sec only in ADJ_SEC.

Reset
REQ-035 While reset=1, the block SHALL be in IDLE with sec_inc, min_inc, clear, blink_min, blink_sec and running at 0 and state=0.
REQ-036 While reset=1, all synchroniser and edge-detect flops SHALL be 0.
REQ-037 A button already held high at reset release SHALL NOT generate a press pulse.
REQ-038 Reset asserted mid-operation SHALL take effect without waiting for a clock edge; any pending strobe SHALL be dropped.

Configuration
REQ-039 With LAP_SPLIT_EN defined, the block SHALL add input btn_lap (synchronised and edge-detected like the other buttons) and output lap_hold (1 bit, registered, reset 0).
REQ-040 With LAP_SPLIT_EN defined, a lap press in RUN SHALL toggle lap_hold; lap_hold SHALL stay high through PAUSED, and SHALL be cleared on entry to IDLE or to either ADJ state.
REQ-041 With LAP_SPLIT_EN defined, lap presses SHALL be ignored outside RUN.
REQ-042 Without LAP_SPLIT_EN, neither btn_lap nor lap_hold SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-043 Reset release, pause press, then 3 tick_1hz with sec_at_59=0 -> state 0 -> 1, three sec_inc pulses, min_inc never asserted.
REQ-044 In RUN, tick_1hz with sec_at_59=1 -> sec_inc and min_inc both high in the same single cycle.
REQ-045 sw_adj=1, sw_sel=0, then 2 tick_2hz -> state 3, blink_min=1, two min_inc and zero sec_inc; then sw_sel=1 -> state 4, blink_sec=1.
REQ-046 In RUN, clear press and pause press in the same cycle, coincident with tick_1hz -> state 0, clear high one cycle, no inc strobe.
REQ-047 In ADJ_SEC, sw_adj=0 -> state 2; a following pause press -> state 1.
REQ-048 Reset asserted mid-RUN with btn_pause held high, then released -> outputs 0 immediately, state 0, and no transition until btn_pause goes low and then high again.
